// File: rtl/rank_order_pkg.sv
// Shared helpers and reset defaults for the weighted rank-order filter.
// A unit weight per tap with a threshold of N/2+1 reproduces a plain median.
package rank_order_pkg;

    localparam int unsigned DEF_WEIGHT = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    function automatic int unsigned def_threshold(input int unsigned n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/wos_select.sv
// Combinational weighted order-statistic selector.
// Returns the smallest window value whose cumulative tap weight reaches T.
module wos_select #(
    parameter int unsigned N         = 5,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned W_BITS    = 4,
    parameter int unsigned THR_BITS  = 7
) (
    input  logic [N-1:0][DATA_BITS-1:0] win_i,
    input  logic [N-1:0][W_BITS-1:0]    w_i,
    input  logic [THR_BITS-1:0]         thr_i,
    output logic [DATA_BITS-1:0]        data_c,
    output logic                        sat_c
);

    logic [THR_BITS-1:0]  t;
    logic [THR_BITS-1:0]  total;
    logic [THR_BITS-1:0]  cum;
    logic [DATA_BITS-1:0] vmax;
    logic [DATA_BITS-1:0] best;

    always_comb begin
        t     = (thr_i == '0) ? THR_BITS'(1) : thr_i;
        total = '0;
        cum   = '0;
        vmax  = win_i[0];
        for (int i = 0; i < int'(N); i++) begin
            total = total + THR_BITS'(w_i[i]);
            if (win_i[i] > vmax) vmax = win_i[i];
        end
        // The maximum always qualifies unless T exceeds the total weight.
        best = vmax;
        for (int j = 0; j < int'(N); j++) begin
            cum = '0;
            for (int i = 0; i < int'(N); i++) begin
                if (win_i[i] <= win_i[j]) cum = cum + THR_BITS'(w_i[i]);
            end
            if ((cum >= t) && (win_i[j] < best)) best = win_i[j];
        end
        data_c = best;
        sat_c  = (t > total);
    end

endmodule

// File: rtl/weighted_rank_order.sv
// Sliding-window weighted rank-order filter: window, fill counter,
// per-tap weight/threshold registers and a registered result.
module weighted_rank_order
    import rank_order_pkg::*;
#(
    parameter int unsigned N          = 5,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned W_BITS     = 4,
    localparam int unsigned AW        = clog2(N + 1),
    localparam int unsigned THR_BITS  = W_BITS + clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [THR_BITS-1:0]  cfg_wdata,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_sat
);

    logic [N-1:0][DATA_BITS-1:0] win_q, win_d;
    logic [AW-1:0]               fill_q, fill_d;
    logic [N-1:0][W_BITS-1:0]    w_q, w_d;
    logic [THR_BITS-1:0]         thr_q, thr_d;
    logic                        acc_q, acc_d;
    logic                        out_valid_q, out_valid_d;
    logic [DATA_BITS-1:0]        out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;
    logic [DATA_BITS-1:0]        sel_data_c;
    logic                        sel_sat_c;

    wos_select #(
        .N         (N),
        .DATA_BITS (DATA_BITS),
        .W_BITS    (W_BITS),
        .THR_BITS  (THR_BITS)
    ) u_sel (
        .win_i  (win_q),
        .w_i    (w_q),
        .thr_i  (thr_q),
        .data_c (sel_data_c),
        .sat_c  (sel_sat_c)
    );

    always_comb begin
        win_d       = win_q;
        fill_d      = fill_q;
        w_d         = w_q;
        thr_d       = thr_q;
        acc_d       = in_valid;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (in_valid) begin
            win_d = {win_q[N-2:0], in_data};
            if (fill_q != AW'(N)) fill_d = fill_q + AW'(1);
        end

        // Addresses above N fall through both matches and are dropped.
        if (cfg_we) begin
            for (int i = 0; i < int'(N); i++) begin
                if (cfg_addr == AW'(i)) w_d[i] = cfg_wdata[W_BITS-1:0];
            end
            if (cfg_addr == AW'(N)) thr_d = cfg_wdata;
        end

        if (acc_q && (fill_q == AW'(N))) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_c;
            out_sat_d   = sel_sat_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q       <= '0;
            fill_q      <= '0;
            w_q         <= {N{W_BITS'(DEF_WEIGHT)}};
            thr_q       <= THR_BITS'(def_threshold(N));
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            win_q       <= win_d;
            fill_q      <= fill_d;
            w_q         <= w_d;
            thr_q       <= thr_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_weighted_rank_order.sv
// Bench for weighted_rank_order: directed scenarios plus random traffic,
// compared every cycle against a value-domain reference model.
module tb_weighted_rank_order;
    import rank_order_pkg::*;

    localparam int N   = 5;
    localparam int DB  = 8;
    localparam int WB  = 4;
    localparam int AW  = 3;
    localparam int TB  = 7;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DB-1:0] in_data;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [TB-1:0] cfg_wdata;
    logic          out_valid;
    logic [DB-1:0] out_data;
    logic          out_sat;

    weighted_rank_order #(.N(N), .DATA_BITS(DB), .W_BITS(WB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: m_win[0] is the newest sample.
    int m_win [N];
    int m_w   [N];
    int m_thr;
    int m_fill;
    bit m_pend;
    int exp_valid, exp_data, exp_sat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_win[i] = 0;
            m_w[i]   = int'(DEF_WEIGHT);
        end
        m_thr     = int'(def_threshold(N));
        m_fill    = 0;
        m_pend    = 1'b0;
        exp_valid = 0;
        exp_data  = 0;
        exp_sat   = 0;
    endfunction

    // Scan every possible value upward; first one whose covered weight reaches T wins.
    function automatic void ref_result(output int d, output int s);
        int t, total, wsum, mx;
        bit found;
        t     = (m_thr == 0) ? 1 : m_thr;
        total = 0;
        mx    = 0;
        for (int i = 0; i < N; i++) begin
            total += m_w[i];
            if (m_win[i] > mx) mx = m_win[i];
        end
        d     = mx;
        s     = (t > total) ? 1 : 0;
        found = 1'b0;
        if (s == 0) begin
            for (int v = 0; v < (1 << DB); v++) begin
                wsum = 0;
                for (int i = 0; i < N; i++) if (m_win[i] <= v) wsum += m_w[i];
                if (!found && wsum >= t) begin
                    d     = v;
                    found = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_edge(input bit v, input int d, input bit we, input int a, input int wd);
        if (m_pend && m_fill == N) begin
            ref_result(exp_data, exp_sat);
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        m_pend = v;
        if (we) begin
            if (a < N) m_w[a] = wd % (1 << WB);
            else if (a == N) m_thr = wd % (1 << TB);
        end
        if (v) begin
            for (int i = N - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = d;
            if (m_fill < N) m_fill++;
        end
    endfunction

    task automatic step(input bit v, input int d, input bit we, input int a, input int wd);
        in_valid  = v;
        in_data   = DB'(d);
        cfg_we    = we;
        cfg_addr  = AW'(a);
        cfg_wdata = TB'(wd);
        @(posedge clk);
        model_edge(v, d, we, a, wd);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("out_data",  32'(out_data),  32'(exp_data));
        chk("out_sat",   32'(out_sat),   32'(exp_sat));
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_sat",   32'(out_sat),   32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic feed(input int d);
        step(1'b1, d, 1'b0, 0, 0);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        int seq_a [5];
        int seq_b [5];
        int seq_c [5];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        m_reset();
        do_reset();

        // Default median over 10,50,30,20,40.
        seq_a = '{10, 50, 30, 20, 40};
        foreach (seq_a[i]) feed(seq_a[i]);
        chk("median_no_early_pulse", 32'(out_valid), 32'd0);
        idle();
        chk("median_pulse", 32'(out_valid), 32'd1);
        chk("median_value", 32'(out_data), 32'd30);
        chk("median_sat",   32'(out_sat),  32'd0);
        idle();
        chk("median_single_pulse", 32'(out_valid), 32'd0);
        chk("median_hold", 32'(out_data), 32'd30);

        // Heavier newest tap, T=4.
        step(1'b0, 0, 1'b1, 0, 3);
        step(1'b0, 0, 1'b1, N, 4);
        feed(40);
        idle();
        chk("wt_thr4", 32'(out_data), 32'd40);
        // Threshold 0 behaves as 1 (window minimum); write coincides with the sample.
        step(1'b1, 40, 1'b1, N, 0);
        idle();
        chk("wt_thr0", 32'(out_data), 32'd20);
        // Threshold above total weight 7 saturates to the maximum.
        step(1'b1, 10, 1'b1, N, 20);
        idle();
        chk("sat_value", 32'(out_data), 32'd40);
        chk("sat_flag",  32'(out_sat),  32'd1);

        // Duplicates, back to back and then with gaps.
        do_reset();
        seq_b = '{7, 7, 7, 3, 3};
        foreach (seq_b[i]) feed(seq_b[i]);
        idle();
        chk("dup_value", 32'(out_data), 32'd7);
        do_reset();
        foreach (seq_b[i]) begin
            feed(seq_b[i]);
            idle();
            idle();
        end
        chk("dup_gap_value", 32'(out_data), 32'd7);

        // Reset mid-stream, then out-of-range config writes alongside new samples.
        do_reset();
        feed(100);
        feed(200);
        feed(150);
        do_reset();
        seq_c = '{9, 1, 5, 3, 8};
        foreach (seq_c[i]) step(1'b1, seq_c[i], 1'b1, 6 + (i % 2), 1);
        idle();
        chk("post_reset_pulse", 32'(out_valid), 32'd1);
        chk("post_reset_value", 32'(out_data), 32'd5);

        // Random traffic with occasional config writes and resets.
        for (int c = 0; c < 3000; c++) begin
            bit v, we;
            int d, a, wd;
            v  = ($urandom_range(0, 9) < 7);
            d  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
            we = ($urandom_range(0, 14) == 0);
            a  = int'($urandom_range(0, 7));
            wd = (a == N) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 127));
            if ($urandom_range(0, 399) == 0) do_reset();
            else step(v, d, we, a, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
